// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-panel controller.
// Holds the FSM state encoding, BCD/preset widths and the seconds-tens
// limit used to validate an mm:ss preset before cooking starts.
package microwave_pkg;

  localparam int BCD_W    = 4;
  localparam int PRESET_W = 16;

  // Largest legal seconds-tens digit (mm:59 is the longest valid seconds field).
  localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;
  localparam logic [BCD_W-1:0] MAX_DIGIT    = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COOK  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Countdown-step prescaler: mod-TICK_DIV counter.
// Ports:
//   clk_i    - system clock
//   clr_i    - synchronous active-high reset
//   clear_i  - synchronous clear of the count (takes priority over counting)
//   cnt_en_i - advance the count this cycle; when low the count is held
//   tick_o   - combinational one-cycle pulse on the cycle the count wraps
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic clear_i,
  input  logic cnt_en_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave front-panel controller. Collects BCD keypad digits into an
// mm:ss preset, drives load/clear/enable of the downstream countdown chain
// and sequences cook, pause and done. All outputs are registered.
// Ports:
//   clk_i, clr_i        - clock, synchronous active-high reset
//   key_valid_i/digit_i - keypad strobe and BCD digit
//   start_i, stop_i     - start/resume and stop/cancel requests (levels)
//   door_open_i         - door switch, 1 = open
//   timer_zero_i        - counter chain reached 00:00
//   preset_o            - BCD mm:ss to counter data inputs
//   loadn_o, clrn_o     - active-low load / clear to counters
//   en_o                - count-down enable, one-cycle pulses
//   mag_on_o, beep_o    - magnetron and buzzer drive
//   state_o             - current FSM state (debug)
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int BEEP_CYCLES = 30
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                key_valid_i,
  input  logic [BCD_W-1:0]    key_digit_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                door_open_i,
  input  logic                timer_zero_i,
  output logic [PRESET_W-1:0] preset_o,
  output logic                loadn_o,
  output logic                clrn_o,
  output logic                en_o,
  output logic                mag_on_o,
  output logic                beep_o,
  output logic [2:0]          state_o
);

  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BEEP = BW'(BEEP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PRESET_W-1:0] preset_q, preset_d;
  logic [BW-1:0]       beep_cnt_q, beep_cnt_d;
  logic                loadn_q, clrn_q, clrn_d, en_q, mag_on_q, beep_q;
  logic                key_ok, start_ok, tick;
  logic [PRESET_W-1:0] shifted;

  // Prescaler only runs while cooking; LOAD restarts it, PAUSE holds it.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk_i    (clk_i),
    .clr_i    (clr_i),
    .clear_i  (state_q == ST_LOAD),
    .cnt_en_i (state_q == ST_COOK),
    .tick_o   (tick)
  );

  assign key_ok   = key_valid_i && is_bcd_digit(key_digit_i);
  assign shifted  = {preset_q[PRESET_W-BCD_W-1:0], key_digit_i};
  // Only the seconds-tens digit is range-checked; minutes may be 00..99.
  assign start_ok = start_i && !door_open_i && (preset_q != '0) &&
                    (preset_q[7:4] <= MAX_SEC_TENS);

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    clrn_d     = 1'b1;
    beep_cnt_d = (state_q == ST_DONE) ? beep_cnt_q + 1'b1 : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (stop_i) begin
          preset_d = '0;
        end else if (key_ok) begin
          preset_d = shifted;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop_i) begin
          preset_d = '0;
          state_d  = ST_IDLE;
        end else if (start_ok) begin
          state_d = ST_LOAD;
        end else if (key_ok) begin
          preset_d = shifted;
        end
      end
      ST_LOAD: state_d = ST_COOK;
      ST_COOK: begin
        if (timer_zero_i)                 state_d = ST_DONE;
        else if (stop_i || door_open_i)   state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_i) begin
          preset_d = '0;
          clrn_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (start_i && !door_open_i) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop_i || beep_cnt_q == LAST_BEEP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q    <= ST_IDLE;
      preset_q   <= '0;
      beep_cnt_q <= '0;
      loadn_q    <= 1'b1;
      clrn_q     <= 1'b0;
      en_q       <= 1'b0;
      mag_on_q   <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      beep_cnt_q <= beep_cnt_d;
      clrn_q     <= clrn_d;
      // Outputs decode the next state so they line up with state_q.
      loadn_q    <= (state_d != ST_LOAD);
      mag_on_q   <= (state_d == ST_COOK);
      beep_q     <= (state_d == ST_DONE);
      // A wrap on the edge that leaves COOK is dropped, never delayed.
      en_q       <= tick && (state_d == ST_COOK);
    end
  end

  assign preset_o = preset_q;
  assign loadn_o  = loadn_q;
  assign clrn_o   = clrn_q;
  assign en_o     = en_q;
  assign mag_on_o = mag_on_q;
  assign beep_o   = beep_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;
  localparam int TICK_DIV    = 10;
  localparam int BEEP_CYCLES = 30;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_COOK = 3, M_PAUSE = 4, M_DONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, key_valid, start, stop, door_open, timer_zero;
  logic [3:0]  key_digit;
  logic [15:0] preset;
  logic        loadn, clrn, en, mag_on, beep;
  logic [2:0]  state;

  microwave_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_CYCLES(BEEP_CYCLES)) dut (
    .clk_i(clk), .clr_i(clr), .key_valid_i(key_valid), .key_digit_i(key_digit),
    .start_i(start), .stop_i(stop), .door_open_i(door_open), .timer_zero_i(timer_zero),
    .preset_o(preset), .loadn_o(loadn), .clrn_o(clrn), .en_o(en),
    .mag_on_o(mag_on), .beep_o(beep), .state_o(state)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: keypad digits as an array, cooked time as a phase
  // within the current countdown step, remaining buzzer time.
  int m_state = M_IDLE;
  int m_dig[4] = '{0, 0, 0, 0};
  int m_phase = 0;
  int m_beep_left = 0;
  bit m_en = 0, m_clrn = 0;

  function automatic logic [15:0] m_preset();
    return 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
  endfunction

  task automatic m_push(input int d);
    m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0]; m_dig[0] = d;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic model_edge();
    bit key_ok, wrapped;
    m_en = 0; m_clrn = 1;
    key_ok = key_valid && (int'(key_digit) <= 9);
    if (clr) begin
      m_state = M_IDLE; m_clear(); m_phase = 0; m_beep_left = 0; m_clrn = 0;
      return;
    end
    case (m_state)
      M_IDLE: begin
        if (stop) m_clear();
        else if (key_ok) begin m_push(int'(key_digit)); m_state = M_ENTRY; end
      end
      M_ENTRY: begin
        if (stop) begin m_clear(); m_state = M_IDLE; end
        else if (start && !door_open && (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] > 0)
                 && m_dig[1] <= 5) m_state = M_LOAD;
        else if (key_ok) m_push(int'(key_digit));
      end
      M_LOAD: begin m_phase = 0; m_state = M_COOK; end
      M_COOK: begin
        m_phase++;
        wrapped = (m_phase == TICK_DIV);
        if (wrapped) m_phase = 0;
        if (timer_zero) begin m_state = M_DONE; m_beep_left = BEEP_CYCLES; end
        else if (stop || door_open) m_state = M_PAUSE;
        else m_en = wrapped;
      end
      M_PAUSE: begin
        if (stop) begin m_clear(); m_clrn = 0; m_state = M_IDLE; end
        else if (start && !door_open) m_state = M_COOK;
      end
      M_DONE: begin
        m_beep_left--;
        if (stop || m_beep_left == 0) m_state = M_IDLE;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("state",  32'(state),  32'(m_state));
    check("preset", 32'(preset), 32'(m_preset()));
    check("loadn",  32'(loadn),  32'(m_state != M_LOAD));
    check("clrn",   32'(clrn),   32'(m_clrn));
    check("en",     32'(en),     32'(m_en));
    check("mag_on", 32'(mag_on), 32'(m_state == M_COOK));
    check("beep",   32'(beep),   32'(m_state == M_DONE));
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; tick(); key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int n, w;
    clr = 1; key_valid = 0; key_digit = 0; start = 0; stop = 0; door_open = 0; timer_zero = 0;
    tick(); tick();
    check("rst_state",  32'(state),  32'(M_IDLE));
    check("rst_preset", 32'(preset), 32'h0);
    check("rst_loadn",  32'(loadn),  32'h1);
    check("rst_clrn",   32'(clrn),   32'h0);
    check("rst_en",     32'(en),     32'h0);
    check("rst_mag",    32'(mag_on), 32'h0);
    check("rst_beep",   32'(beep),   32'h0);
    clr = 0; tick();
    check("clrn_release", 32'(clrn), 32'h1);

    press(4'd1); press(4'd3); press(4'd0);
    check("preset_0130", 32'(preset), 32'h0130);
    check("entry_state", 32'(state), 32'(M_ENTRY));
    press(4'hC);
    check("bad_digit", 32'(preset), 32'h0130);

    // 00:70 has an illegal seconds field
    press(4'd0); press(4'd0); press(4'd7); press(4'd0);
    check("preset_0070", 32'(preset), 32'h0070);
    pulse_start();
    check("reject_70", 32'(state), 32'(M_ENTRY));

    press(4'd0); press(4'd0); press(4'd4); press(4'd5);
    check("preset_0045", 32'(preset), 32'h0045);
    door_open = 1; pulse_start();
    check("reject_door", 32'(state), 32'(M_ENTRY));
    door_open = 0; pulse_start();
    check("load_state", 32'(state), 32'(M_LOAD));
    check("load_low", 32'(loadn), 32'h0);
    check("load_nomag", 32'(mag_on), 32'h0);
    tick();
    check("load_release", 32'(loadn), 32'h1);
    check("cook_mag", 32'(mag_on), 32'h1);

    for (int k = 1; k <= 3 * TICK_DIV; k++) begin
      tick();
      check("en_cadence", 32'(en), 32'((k % TICK_DIV) == 0));
    end

    timer_zero = 1; tick(); timer_zero = 0;
    check("done_state", 32'(state), 32'(M_DONE));
    check("done_mag", 32'(mag_on), 32'h0);
    n = beep ? 1 : 0;
    for (int j = 0; j < 100 && beep; j++) begin
      tick();
      if (beep) n++;
    end
    check("beep_len", 32'(n), 32'(BEEP_CYCLES));
    check("done_idle", 32'(state), 32'(M_IDLE));
    check("preset_kept", 32'(preset), 32'h0045);

    // Door opened mid-cook after 4 cooking cycles
    press(4'd1);
    check("preset_0451", 32'(preset), 32'h0451);
    pulse_start(); tick();
    tick(); tick(); tick();
    door_open = 1; tick();
    check("door_pause", 32'(state), 32'(M_PAUSE));
    check("door_mag", 32'(mag_on), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("pause_en", 32'(en), 32'h0);
    end
    door_open = 0; pulse_start();
    check("resume_mag", 32'(mag_on), 32'h1);
    w = 0;
    for (int j = 0; j < 50; j++) begin
      tick(); w++;
      if (en) break;
    end
    check("resume_en", 32'(w), 32'(TICK_DIV - 4));

    door_open = 1; tick(); door_open = 0;
    stop = 1; tick(); stop = 0;
    check("stop_clrn", 32'(clrn), 32'h0);
    check("stop_preset", 32'(preset), 32'h0);
    check("stop_idle", 32'(state), 32'(M_IDLE));
    tick();
    check("stop_clrn_rel", 32'(clrn), 32'h1);

    press(4'd2); press(4'd0); pulse_start(); tick(); tick(); tick();
    clr = 1; tick(); clr = 0;
    check("clr_state", 32'(state), 32'(M_IDLE));
    check("clr_preset", 32'(preset), 32'h0);
    check("clr_mag", 32'(mag_on), 32'h0);
    check("clr_clrn", 32'(clrn), 32'h0);

    press(4'd0);
    pulse_start();
    check("reject_zero", 32'(state), 32'(M_ENTRY));
    stop = 1; tick(); stop = 0;

    for (int i = 0; i < 4000; i++) begin
      clr        = ($urandom_range(0, 199) == 0);
      key_valid  = ($urandom_range(0, 3) == 0);
      key_digit  = 4'($urandom_range(0, 15));
      start      = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 24) == 0);
      timer_zero = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) door_open = ~door_open;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
